// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single 16-bit SRAM port between port 0 (CPU) and port 1 (video/DMA).
// Latency: ack 1 cycle after req is sampled, read rdata/rvalid 3 cycles after; writes 1/cycle, reads 1 per 2 cycles.
// Backpressure: requesters hold req until ack; no grant from READ, a tie loser wins the next grant opportunity.
// Option: define RAM_ARB_FIXED_PRI_EN to make port 1 win every tie (round-robin otherwise).
module ram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_rvalid,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_rvalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_dataIn,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_dataOut,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, READ_WAIT} state_t;

  state_t              state;
  logic                rd_port;     // port that owns the read in flight
`ifndef RAM_ARB_FIXED_PRI_EN
  logic                last_grant;  // most recent winner, loses the next tie
`endif
  logic                can_grant;
  logic                winner;
  logic                g_we;
  logic [ADDR_W-1:0]   g_addr;
  logic [DATA_W-1:0]   g_wdata;

  // The SRAM is still finishing a read capture in READ, so that is the only state that cannot grant.
  assign can_grant = (state != READ) && (p0_req || p1_req);

  // Pick the winning port and mux its request fields.
  always_comb begin
`ifdef RAM_ARB_FIXED_PRI_EN
    winner = p1_req;
`else
    if (p0_req && p1_req) begin
      winner = ~last_grant;
    end else begin
      winner = p1_req;
    end
`endif
    g_we    = winner ? p1_we    : p0_we;
    g_addr  = winner ? p1_addr  : p0_addr;
    g_wdata = winner ? p1_wdata : p0_wdata;
  end

  // Sequencer: grants, SRAM drive registers, read return and busy, all registered.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      rd_port     <= 1'b0;
`ifndef RAM_ARB_FIXED_PRI_EN
      last_grant  <= 1'b1;
`endif
      ram_address <= '0;
      ram_dataIn  <= '0;
      ram_write   <= 1'b0;
      p0_ack      <= 1'b0;
      p1_ack      <= 1'b0;
      p0_rvalid   <= 1'b0;
      p1_rvalid   <= 1'b0;
      p0_rdata    <= '0;
      p1_rdata    <= '0;
      busy        <= 1'b0;
    end else begin
      p0_ack    <= 1'b0;
      p1_ack    <= 1'b0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;

      // ram_dataOut now holds the word captured at the end of READ.
      if (state == READ_WAIT) begin
        if (rd_port) begin
          p1_rdata  <= ram_dataOut;
          p1_rvalid <= 1'b1;
        end else begin
          p0_rdata  <= ram_dataOut;
          p0_rvalid <= 1'b1;
        end
      end

      if (can_grant) begin
        // Address, data and write strobe move together so write data never rides a read cycle.
        ram_address <= g_addr;
        ram_dataIn  <= g_wdata;
        ram_write   <= g_we;
`ifndef RAM_ARB_FIXED_PRI_EN
        last_grant  <= winner;
`endif
        p0_ack      <= ~winner;
        p1_ack      <= winner;
        if (!g_we) begin
          rd_port <= winner;
        end
        state <= g_we ? WRITE : READ;
        busy  <= 1'b1;
      end else begin
        ram_write <= 1'b0;
        if (state == READ) begin
          state <= READ_WAIT;
          busy  <= 1'b1;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end
    end
  end

endmodule
